// File: rtl/uc_multiciclo_if.sv
// Signal bundle between the multicycle control unit and its datapath/memory.
// The master drives the instruction, flag and memory-ack inputs; the slave is the control unit.
interface uc_multiciclo_if #(
   parameter int OPW  = 6,
   parameter int ALUW = 3
);
   logic            run;
   logic [OPW-1:0]  Opcode;
   logic            z;
   logic            mem_ack;
   logic            pc_en;
   logic            s_inc;
   logic            s_ret;
   logic            s_inm;
   logic            we3;
   logic            wez;
   logic [ALUW-1:0] Op;
   logic            push;
   logic            pop;
   logic            mem_req;
   logic            mem_we;
   logic            halted;
   logic            ill_op;
   logic            stk_err;

   modport master (
      output run, Opcode, z, mem_ack,
      input  pc_en, s_inc, s_ret, s_inm, we3, wez, Op,
             push, pop, mem_req, mem_we, halted, ill_op, stk_err
   );

   modport slave (
      input  run, Opcode, z, mem_ack,
      output pc_en, s_inc, s_ret, s_inm, we3, wez, Op,
             push, pop, mem_req, mem_we, halted, ill_op, stk_err
   );
endinterface

// File: rtl/uc_multiciclo.sv
// Multicycle control unit: IDLE/FETCH/EXEC/MEM/HALT sequencer with a bounded
// call-depth tracker and sticky illegal-opcode / stack-error flags.
module uc_multiciclo #(
   parameter int OPW    = 6,
   parameter int ALUW   = 3,
   parameter int SDEPTH = 4
) (
   input logic        clk,
   input logic        reset,
   uc_multiciclo_if.slave bus
);
   typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;

   localparam logic [3:0] SDEPTH_L = 4'(SDEPTH);

   state_t          state_reg, state_next;
   logic [OPW-1:0]  ir_reg;
   logic [3:0]      depth_reg, depth_next;
   logic            ill_reg, stk_reg;
   logic            set_ill, set_stk;

   logic            pc_en, s_inc, s_ret, s_inm, we3, wez;
   logic [ALUW-1:0] op;
   logic            push, pop, mem_req, mem_we;

   logic [1:0]      cls;
   logic [2:0]      sub;
   logic            is_st;
   logic            unused_bits;

   assign cls         = ir_reg[OPW-1:OPW-2];
   assign sub         = ir_reg[2:0];
   assign is_st       = (cls == 2'b00) && (sub == 3'b100);
   assign unused_bits = ^ir_reg[OPW-3:3];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         ir_reg    <= '0;
         depth_reg <= '0;
         ill_reg   <= 1'b0;
         stk_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         depth_reg <= depth_next;
         if (state_reg == FETCH)
            ir_reg <= bus.Opcode;
         if (set_ill)
            ill_reg <= 1'b1;
         if (set_stk)
            stk_reg <= 1'b1;
      end
   end

   always_comb begin
      state_next = state_reg;
      depth_next = depth_reg;
      set_ill    = 1'b0;
      set_stk    = 1'b0;
      pc_en      = 1'b0;
      s_inc      = 1'b1;
      s_ret      = 1'b0;
      s_inm      = 1'b0;
      we3        = 1'b0;
      wez        = 1'b0;
      op         = '0;
      push       = 1'b0;
      pop        = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;

      case (state_reg)
         IDLE: begin
            s_inc = 1'b0;
            if (bus.run)
               state_next = FETCH;
         end
         FETCH: state_next = EXEC;
         EXEC: begin
            state_next = FETCH;
            pc_en      = 1'b1;
            if (ir_reg[OPW-1]) begin
               op  = ir_reg[ALUW-1:0];
               we3 = 1'b1;
               wez = 1'b1;
            end else if (cls == 2'b00) begin
               case (sub)
                  3'b000: ;
                  3'b001: begin s_inm = 1'b1; we3 = 1'b1; end
                  3'b010: begin pc_en = 1'b0; state_next = HALT; end
                  3'b011, 3'b100: begin
                     pc_en      = 1'b0;
                     mem_req    = 1'b1;
                     mem_we     = sub[2];
                     state_next = MEM;
                  end
                  default: set_ill = 1'b1;
               endcase
            end else begin
               case (sub)
                  3'b000: s_inc = 1'b0;
                  3'b001: s_inc = !bus.z;
                  3'b010: s_inc = bus.z;
                  3'b011: begin
                     // a CALL beyond the tracked depth would overflow the return stack
                     if (depth_reg < SDEPTH_L) begin
                        push       = 1'b1;
                        s_inc      = 1'b0;
                        depth_next = depth_reg + 4'd1;
                     end else
                        set_stk = 1'b1;
                  end
                  3'b100: begin
                     if (depth_reg != 4'd0) begin
                        pop        = 1'b1;
                        s_ret      = 1'b1;
                        depth_next = depth_reg - 4'd1;
                     end else
                        set_stk = 1'b1;
                  end
                  default: set_ill = 1'b1;
               endcase
            end
         end
         MEM: begin
            mem_req = 1'b1;
            mem_we  = is_st;
            if (bus.mem_ack) begin
               pc_en      = 1'b1;
               we3        = !is_st;
               state_next = FETCH;
            end
         end
         HALT: s_inc = 1'b0;
         default: begin
            s_inc      = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   assign bus.pc_en   = pc_en;
   assign bus.s_inc   = s_inc;
   assign bus.s_ret   = s_ret;
   assign bus.s_inm   = s_inm;
   assign bus.we3     = we3;
   assign bus.wez     = wez;
   assign bus.Op      = op;
   assign bus.push    = push;
   assign bus.pop     = pop;
   assign bus.mem_req = mem_req;
   assign bus.mem_we  = mem_we;
   assign bus.halted  = (state_reg == HALT);
   assign bus.ill_op  = ill_reg;
   assign bus.stk_err = stk_reg;
endmodule

// File: doc/uc_multiciclo.md
UC_MULTICICLO -- requirements
Module: uc_multiciclo

Interface
REQ-001 The block SHALL have parameter OPW, default 6, opcode width (>=6).
REQ-002 The block SHALL have parameter ALUW, default 3, ALU operation width (1..OPW-1).
REQ-003 The block SHALL have parameter SDEPTH, default 4, maximum CALL nesting depth (1..15).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- run  in  1  start execution from IDLE
- Opcode  in  OPW  opcode of the current instruction word
- z  in  1  zero flag from the datapath flag register
- mem_ack  in  1  data-memory completion
- pc_en  out  1  PC load enable
- s_inc  out  1  PC source: 1 = PC+1, 0 = jump target
- s_ret  out  1  PC source: return address from stack (overrides s_inc)
- s_inm  out  1  register-file write source: 1 = immediate
- we3  out  1  register-file write enable
- wez  out  1  zero-flag write enable
- Op  out  ALUW  ALU operation
- push, pop  out  1  return-stack controls
- mem_req, mem_we  out  1  data-memory request / write
- halted  out  1  HALT reached
- ill_op, stk_err  out  1  sticky error flags

Function
REQ-006 States SHALL be IDLE, FETCH, EXEC, MEM, HALT; state and latched opcode (ir) are registered; outputs are decoded from state, ir, z and mem_ack.
REQ-007 IDLE SHALL go to FETCH when run=1, else remain; all outputs 0.
REQ-008 FETCH SHALL latch Opcode into ir and go to EXEC; all enables 0.
REQ-009 Decode: ir[OPW-1]=1 -> ALU: Op=ir[ALUW-1:0], we3=1, wez=1, s_inm=0.
REQ-010 Decode: ir[OPW-1:OPW-2]=00, sub=ir[2:0]: 000 NOP, 001 LI (s_inm=1, we3=1, wez=0), 010 HALT, 011 LD, 100 ST.
REQ-011 Decode: ir[OPW-1:OPW-2]=01, sub=ir[2:0]: 000 J, 001 JZ, 010 JNZ, 011 CALL, 100 RET.
REQ-012 Any other encoding SHALL execute as NOP and set ill_op.
REQ-013 EXEC SHALL assert pc_en=1 for 1 cycle, then go to FETCH; instruction latency is 2 cycles.
REQ-014 Jumps: J gives s_inc=0; JZ gives s_inc=!z; JNZ gives s_inc=z; z is sampled in EXEC.
REQ-015 CALL with depth<SDEPTH SHALL assert push=1, s_inc=0 and increment depth; with depth=SDEPTH it SHALL set stk_err and behave as NOP.
REQ-016 RET with depth>0 SHALL assert pop=1, s_ret=1 and decrement depth; with depth=0 it SHALL set stk_err and behave as NOP.
REQ-017 LD/ST in EXEC SHALL assert mem_req=1 with pc_en=0 and go to MEM; mem_we=1 for ST only.
REQ-018 MEM SHALL hold mem_req/mem_we until a cycle with mem_ack=1; in that cycle pc_en=1, s_inc=1, and LD also asserts we3=1; then go to FETCH.
REQ-019 mem_ack outside MEM SHALL be ignored.
REQ-020 HALT in EXEC SHALL go to HALT with pc_en=0; HALT is absorbing; halted=1, all enables 0.
REQ-021 Default outputs: s_inc=1, all others 0.
REQ-022 ill_op and stk_err SHALL be sticky until reset.
REQ-023 pc_en, we3, wez, push, pop SHALL never be 1 in IDLE, FETCH or HALT.

Reset
REQ-024 reset=1 SHALL immediately force state=IDLE, ir=0, depth=0, all outputs 0 (including mem_req mid-MEM), ill_op=0, stk_err=0.
REQ-025 After reset deasserts, the block SHALL remain in IDLE until run=1.

Verification
REQ-026 run=1, LI (000001) then ALU 100011 -> EXEC cycles show s_inm=1, we3=1, wez=0, then Op=011, we3=1, wez=1; pc_en=1 every 2nd cycle.
REQ-027 JZ (010001) with z=1 -> s_inc=0; with z=0 -> s_inc=1; JNZ (010010) gives the inverse.
REQ-028 SDEPTH=2: three CALLs then three RETs -> push on CALL 1-2, stk_err=1 on CALL 3; pop+s_ret on RET 1-2; RET 3 is a NOP.
REQ-029 LD (000011) with mem_ack delayed 3 cycles -> mem_req=1 for 4 cycles, we3=1 and pc_en=1 only in the ack cycle; ST gives mem_we=1 and we3=0.
REQ-030 Reset asserted in MEM -> mem_req=0 in the same cycle, state IDLE; HALT (000010) -> halted=1, remains halted until reset; opcode 011111 -> ill_op=1, NOP.
